// File: rtl/tt_macro_vector_driver_if.sv
// ---------------------------------------------------------------------------
// tt_macro_vector_driver_if
//   Command and response handshake bundle between the tile-side byte stream
//   and the macro vector driver.
//
//   Signals:
//     cmd_valid  command byte present on cmd_data
//     cmd_ready  driver accepts a byte this cycle
//     cmd_data   command byte (first of pair = stimulus, second = expected)
//     rsp_valid  capture result available
//     rsp_ready  consumer takes the result this cycle
//     rsp_data   captured macro output byte
//     rsp_match  1 when rsp_data equalled the expected byte
//
//   Modports:
//     master  tile side: issues commands, consumes responses
//     slave   driver side: accepts commands, produces responses
// ---------------------------------------------------------------------------
interface tt_macro_vector_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_match;

  modport master (
    output cmd_valid,
    output cmd_data,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_match
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_match
  );
endinterface : tt_macro_vector_driver_if

// File: rtl/tt_macro_vector_driver.sv
// ---------------------------------------------------------------------------
// tt_macro_vector_driver
//   Stimulus/response driver for a hard macro inside a Tiny Tapeout tile.
//   Takes two-byte vectors (stimulus, expected) from a byte stream, drives
//   the stimulus onto the macro inputs, waits SETTLE_CYCLES edges, captures
//   the macro output and reports it together with a pass/fail flag. Failed
//   vectors are tallied in a saturating 8-bit counter.
//
//   Parameters:
//     SETTLE_CYCLES  edges between expected-byte acceptance and capture
//                    (legal range 1..255)
//
//   Ports:
//     clk_i           single clock, rising-edge
//     rst_i           synchronous active-high reset
//     vec_if          command/response handshake bundle (slave side)
//     stim_o          registered drive to the macro inputs
//     resp_i          macro outputs, only sampled at capture
//     clr_cnt_i       synchronous clear of mismatch_cnt_o (wins over increment)
//     mismatch_cnt_o  saturating count of failed vectors
//     busy_o          driver is not idle
// ---------------------------------------------------------------------------
module tt_macro_vector_driver #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  tt_macro_vector_driver_if.slave   vec_if,
  output logic [7:0]                stim_o,
  input  logic [7:0]                resp_i,
  input  logic                      clr_cnt_i,
  output logic [7:0]                mismatch_cnt_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_EXP = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_REPORT  = 2'd3
  } state_e;

  // Counter preload: the capture edge is the one where the counter reads 0,
  // so loading SETTLE_CYCLES-1 puts capture exactly SETTLE_CYCLES edges
  // after the expected byte is accepted.
  localparam logic [7:0] SETTLE_PRELOAD = 8'(SETTLE_CYCLES - 1);

  // Saturating 8-bit increment; holds at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

  state_e     state_q,     state_d;
  logic [7:0] stim_q,      stim_d;
  logic [7:0] exp_q,       exp_d;
  logic [7:0] cnt_q,       cnt_d;
  logic [7:0] rsp_data_q,  rsp_data_d;
  logic       rsp_match_q, rsp_match_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] mcnt_q,      mcnt_d;
  logic       cap_miss_s;
  logic       cmd_ready_s;

  // Handshake status decoded from state only; forced low while reset is
  // held because the synchronous reset has not yet returned state to IDLE.
  always_comb begin
    cmd_ready_s = 1'b0;
    busy_o      = 1'b0;
    if (rst_i) begin
      cmd_ready_s = 1'b0;
      busy_o      = 1'b0;
    end else begin
      cmd_ready_s = (state_q == ST_IDLE) || (state_q == ST_GET_EXP);
      busy_o      = (state_q != ST_IDLE);
    end
  end

  // Next-state and datapath update for the vector sequencer.
  always_comb begin
    state_d     = state_q;
    stim_d      = stim_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_match_d = rsp_match_q;
    rsp_valid_d = rsp_valid_q;
    cap_miss_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vec_if.cmd_valid && cmd_ready_s) begin
          stim_d  = vec_if.cmd_data;
          state_d = ST_GET_EXP;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GET_EXP: begin
        if (vec_if.cmd_valid && cmd_ready_s) begin
          exp_d   = vec_if.cmd_data;
          cnt_d   = SETTLE_PRELOAD;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_GET_EXP;
        end
      end

      ST_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_SETTLE;
        end else begin
          // Capture edge: resp_i is only ever looked at here.
          rsp_data_d  = resp_i;
          rsp_match_d = (resp_i == exp_q);
          rsp_valid_d = 1'b1;
          cap_miss_s  = (resp_i != exp_q);
          state_d     = ST_REPORT;
        end
      end

      ST_REPORT: begin
        if (rsp_valid_q && vec_if.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_REPORT;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase

    // Clear has priority over a mismatch on the same edge.
    if (clr_cnt_i) begin
      mcnt_d = 8'd0;
    end else if (cap_miss_s) begin
      mcnt_d = sat_inc8(mcnt_q);
    end else begin
      mcnt_d = mcnt_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      stim_q      <= 8'd0;
      exp_q       <= 8'd0;
      cnt_q       <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_match_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      mcnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      stim_q      <= stim_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_match_q <= rsp_match_d;
      rsp_valid_q <= rsp_valid_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign vec_if.cmd_ready = cmd_ready_s;
  assign vec_if.rsp_valid = rsp_valid_q;
  assign vec_if.rsp_data  = rsp_data_q;
  assign vec_if.rsp_match = rsp_match_q;
  assign stim_o           = stim_q;
  assign mismatch_cnt_o   = mcnt_q;

endmodule : tt_macro_vector_driver

// File: tb/tb_tt_macro_vector_driver.sv
// ---------------------------------------------------------------------------
// tb_tt_macro_vector_driver
//   Scoreboard bench: the driver process computes each vector's expected
//   response from a simple macro model (resp = stim ^ xor_mask) and pushes
//   it into a queue; an independent monitor pops and compares whenever a
//   response handshake is about to occur.
// ---------------------------------------------------------------------------
module tb_tt_macro_vector_driver;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] stim;
  logic [7:0] resp;
  logic [7:0] mcnt;
  logic       clr_cnt;
  logic       busy;
  logic [7:0] xor_mask;

  tt_macro_vector_driver_if vif();

  // Macro model: a byte-wide XOR of its inputs with a bench-chosen mask.
  assign resp = stim ^ xor_mask;

  always #5 clk = ~clk;

  tt_macro_vector_driver #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .vec_if         (vif),
    .stim_o         (stim),
    .resp_i         (resp),
    .clr_cnt_i      (clr_cnt),
    .mismatch_cnt_o (mcnt),
    .busy_o         (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       match;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare every response that is about to be handshaken.
  always @(negedge clk) begin
    if (!rst && vif.rsp_valid && vif.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_rsp: got data 0x%0h with empty queue", vif.rsp_data);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", {24'd0, vif.rsp_data}, {24'd0, mon_e.data});
        chk("rsp_match", {31'd0, vif.rsp_match}, {31'd0, mon_e.match});
        chk("mismatch_cnt", {24'd0, mcnt}, {24'd0, mon_e.cnt});
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    vif.cmd_valid = 1'b1;
    vif.cmd_data  = b;
    while (n < 100) begin
      @(negedge clk);
      if (vif.cmd_ready) break;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL cmd_accept_timeout: byte 0x%0h not accepted in 100 cycles", b);
    end
    @(posedge clk);
    #1;
    vif.cmd_valid = 1'b0;
    vif.cmd_data  = 8'($urandom);
  endtask

  task automatic run_vec(input logic [7:0] s, input logic [7:0] e, input logic [7:0] mask,
                         input int stall, input bit clr_cap, input int bp);
    logic [7:0] rd;
    logic       m;
    logic [7:0] hd;
    logic       hm;
    int         lat;
    xor_mask      = mask;
    vif.rsp_ready = (bp == 0);
    push_byte(s);
    chk("stim_after_byte0", {24'd0, stim}, {24'd0, s});
    repeat (stall) begin
      @(posedge clk);
      #1;
      chk("stall_stim", {24'd0, stim}, {24'd0, s});
      chk("stall_busy_ready", {30'd0, busy, vif.cmd_ready}, 32'd3);
    end
    rd = s ^ mask;
    m  = (rd == e);
    if (clr_cap) model_cnt = 0;
    else if (!m) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
    sb.push_back('{data: rd, match: m, cnt: model_cnt[7:0]});
    push_byte(e);
    lat = 0;
    while (!vif.rsp_valid && lat < 300) begin
      lat++;
      if (clr_cap && lat == SETTLE) clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      clr_cnt = 1'b0;
    end
    chk("rsp_latency", lat, SETTLE);
    if (bp > 0) begin
      hd = vif.rsp_data;
      hm = vif.rsp_match;
      repeat (bp) begin
        @(posedge clk);
        #1;
        chk("bp_hold", {19'd0, vif.rsp_valid, vif.rsp_data, vif.rsp_match, vif.cmd_ready, busy},
            {19'd0, 1'b1, hd, hm, 1'b0, 1'b1});
      end
      vif.rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("rsp_done_ready", {30'd0, vif.rsp_valid, vif.cmd_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] mk;
    logic [7:0] e;
    rst           = 1'b1;
    vif.cmd_valid = 1'b0;
    vif.cmd_data  = 8'd0;
    vif.rsp_ready = 1'b1;
    clr_cnt       = 1'b0;
    xor_mask      = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_busy", {30'd0, vif.cmd_ready, busy}, 32'd0);
    chk("reset_state", {stim, mcnt, vif.rsp_data, 6'd0, vif.rsp_valid, vif.rsp_match}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, vif.cmd_ready}, 32'd1);

    // Loopback, inverted macro, then a backpressured failing vector.
    run_vec(8'hA5, 8'hA5, 8'h00, 0, 1'b0, 0);
    run_vec(8'h0F, 8'h0F, 8'hFF, 0, 1'b0, 0);
    run_vec(8'h5A, 8'h00, 8'h00, 0, 1'b0, 10);

    // Reset while settling with stim = 0x3C.
    xor_mask      = 8'h00;
    vif.rsp_ready = 1'b1;
    push_byte(8'h3C);
    chk("stim_3c", {24'd0, stim}, 32'h3C);
    push_byte(8'h3C);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_held_ready_busy", {30'd0, vif.cmd_ready, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_clear", {stim, mcnt, 7'd0, vif.rsp_valid, 7'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, vif.cmd_ready}, 32'd1);
    model_cnt = 0;
    run_vec(8'h11, 8'h11, 8'h00, 0, 1'b0, 0);

    // Stalled expected byte.
    run_vec(8'h77, 8'h77, 8'h00, 5, 1'b0, 0);

    // Randomised vectors.
    for (int i = 0; i < 40; i++) begin
      s  = 8'($urandom);
      mk = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      e  = ($urandom_range(0, 1) == 0) ? (s ^ mk) : 8'($urandom);
      run_vec(s, e, mk, $urandom_range(0, 3), 1'b0, $urandom_range(0, 2));
    end

    // Idle clear, then saturate with 260 failing vectors.
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt   = 1'b0;
    model_cnt = 0;
    chk("idle_clear", {24'd0, mcnt}, 32'd0);
    for (int i = 0; i < 260; i++) begin
      s = 8'($urandom);
      run_vec(s, s, 8'hFF, 0, 1'b0, 0);
      if (i == 254) chk("sat_after_255", {24'd0, mcnt}, 32'd255);
    end
    chk("sat_after_260", {24'd0, mcnt}, 32'd255);

    // Clear on the same edge as a mismatch capture.
    run_vec(8'h33, 8'h33, 8'h01, 0, 1'b1, 0);
    chk("clr_beats_inc", {24'd0, mcnt}, 32'd0);

    repeat (5) @(posedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule : tb_tt_macro_vector_driver
